// File: rtl/reg_file.sv
// 32x32 general-purpose register file with two combinational read ports,
// same-cycle write forwarding, HI/LO pair and a registered write-commit trace.
module reg_file #(
    parameter int unsigned BYPASS_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        reg_write_to_file,
    input  logic [4:0]  reg_write_addr,
    input  logic [31:0] reg_write_data,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    input  logic        hilo_write,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        commit_valid,
    output logic [4:0]  commit_addr,
    output logic [31:0] commit_data,
    output logic [31:0] write_count
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        commit_valid_q, commit_valid_d;
    logic [4:0]  commit_addr_q, commit_addr_d;
    logic [31:0] commit_data_q, commit_data_d;
    logic [31:0] write_count_q, write_count_d;
    logic        wr_acc;

    // rst is folded in so forwarding is suppressed on a reset cycle too
    assign wr_acc = reg_write_to_file && !stall && !rst && (reg_write_addr != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wr_acc) begin
            regs_d[reg_write_addr] = reg_write_data;
        end
        hi_d = hi_q;
        lo_d = lo_q;
        if (hilo_write && !stall) begin
            hi_d = hi_in;
            lo_d = lo_in;
        end
        commit_valid_d = wr_acc;
        commit_addr_d  = wr_acc ? reg_write_addr : commit_addr_q;
        commit_data_d  = wr_acc ? reg_write_data : commit_data_q;
        write_count_d  = write_count_q + {31'd0, wr_acc};
    end

    always_comb begin
        rs_data = '0;
        if (rs_addr != 5'd0) begin
            if ((BYPASS_EN != 0) && wr_acc && (reg_write_addr == rs_addr)) begin
                rs_data = reg_write_data;
            end else begin
                rs_data = regs_q[rs_addr];
            end
        end
    end

    always_comb begin
        rt_data = '0;
        if (rt_addr != 5'd0) begin
            if ((BYPASS_EN != 0) && wr_acc && (reg_write_addr == rt_addr)) begin
                rt_data = reg_write_data;
            end else begin
                rt_data = regs_q[rt_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q         <= '{default: '0};
            hi_q           <= '0;
            lo_q           <= '0;
            commit_valid_q <= 1'b0;
            commit_addr_q  <= '0;
            commit_data_q  <= '0;
            write_count_q  <= '0;
        end else begin
            regs_q         <= regs_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            commit_valid_q <= commit_valid_d;
            commit_addr_q  <= commit_addr_d;
            commit_data_q  <= commit_data_d;
            write_count_q  <= write_count_d;
        end
    end

    assign hi_out       = hi_q;
    assign lo_out       = lo_q;
    assign commit_valid = commit_valid_q;
    assign commit_addr  = commit_addr_q;
    assign commit_data  = commit_data_q;
    assign write_count  = write_count_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: a forwarding instance and a non-forwarding
// instance driven by the same stimulus, checked with immediate assertions.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        reg_write_to_file;
    logic [4:0]  reg_write_addr;
    logic [31:0] reg_write_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data, rt_data;
    logic        hilo_write;
    logic [31:0] hi_in, lo_in;
    logic [31:0] hi_out, lo_out;
    logic        commit_valid;
    logic [4:0]  commit_addr;
    logic [31:0] commit_data;
    logic [31:0] write_count;

    logic [31:0] nb_rs_data, nb_rt_data, nb_hi_out, nb_lo_out;
    logic        nb_commit_valid;
    logic [4:0]  nb_commit_addr;
    logic [31:0] nb_commit_data, nb_write_count;

    int errors = 0;
    int checks = 0;

    reg_file #(.BYPASS_EN(1)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .reg_write_to_file(reg_write_to_file), .reg_write_addr(reg_write_addr),
        .reg_write_data(reg_write_data), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .hilo_write(hilo_write),
        .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out), .lo_out(lo_out),
        .commit_valid(commit_valid), .commit_addr(commit_addr),
        .commit_data(commit_data), .write_count(write_count)
    );

    reg_file #(.BYPASS_EN(0)) dut_nb (
        .clk(clk), .rst(rst), .stall(stall),
        .reg_write_to_file(reg_write_to_file), .reg_write_addr(reg_write_addr),
        .reg_write_data(reg_write_data), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(nb_rs_data), .rt_data(nb_rt_data), .hilo_write(hilo_write),
        .hi_in(hi_in), .lo_in(lo_in), .hi_out(nb_hi_out), .lo_out(nb_lo_out),
        .commit_valid(nb_commit_valid), .commit_addr(nb_commit_addr),
        .commit_data(nb_commit_data), .write_count(nb_write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_write_to_file = 1'b1;
        reg_write_addr    = a;
        reg_write_data    = d;
    endtask

    task automatic wr_off();
        reg_write_to_file = 1'b0;
        reg_write_addr    = '0;
        reg_write_data    = '0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; hilo_write = 1'b0; hi_in = '0; lo_in = '0;
        rs_addr = '0; rt_addr = '0;
        wr_off();
        tick();
        rst = 1'b0;
        rs_addr = 5'd5;
        #1;
        check("rst_hi", hi_out, 32'h0);
        check("rst_lo", lo_out, 32'h0);
        check("rst_cv", {31'd0, commit_valid}, 32'h0);
        check("rst_ca", {27'd0, commit_addr}, 32'h0);
        check("rst_cd", commit_data, 32'h0);
        check("rst_wc", write_count, 32'h0);
        check("rst_r5", rs_data, 32'h0);

        // Basic write then read-back and trace
        rs_addr = 5'd0;
        wr(5'd5, 32'hDEADBEEF);
        tick();
        wr_off();
        rs_addr = 5'd5;
        #1;
        check("w5_rd", rs_data, 32'hDEADBEEF);
        check("w5_cv", {31'd0, commit_valid}, 32'h1);
        check("w5_ca", {27'd0, commit_addr}, 32'd5);
        check("w5_cd", commit_data, 32'hDEADBEEF);
        check("w5_wc", write_count, 32'd1);
        tick();
        check("idle_cv", {31'd0, commit_valid}, 32'h0);
        check("hold_ca", {27'd0, commit_addr}, 32'd5);
        check("hold_cd", commit_data, 32'hDEADBEEF);

        // Write to r0 is ignored
        wr(5'd0, 32'h12345678);
        rs_addr = 5'd0;
        #1;
        check("r0_same", rs_data, 32'h0);
        tick();
        wr_off();
        #1;
        check("r0_rd", rs_data, 32'h0);
        check("r0_cv", {31'd0, commit_valid}, 32'h0);
        check("r0_wc", write_count, 32'd1);
        check("r0_ca", {27'd0, commit_addr}, 32'd5);

        // Forwarding on both ports, then a stalled write that must not forward or store
        wr(5'd7, 32'h11111111);
        tick();
        wr(5'd7, 32'hA5A5A5A5);
        rs_addr = 5'd7; rt_addr = 5'd7;
        #1;
        check("byp_rs", rs_data, 32'hA5A5A5A5);
        check("byp_rt", rt_data, 32'hA5A5A5A5);
        check("nobyp_rs", nb_rs_data, 32'h11111111);
        rt_addr = 5'd5;
        #1;
        check("byp_rt_other", rt_data, 32'hDEADBEEF);
        tick();
        wr(5'd7, 32'h5A5A5A5A);
        stall = 1'b1;
        rt_addr = 5'd7;
        #1;
        check("stl_rs", rs_data, 32'hA5A5A5A5);
        check("stl_rt", rt_data, 32'hA5A5A5A5);
        tick();
        check("stl_cv", {31'd0, commit_valid}, 32'h0);
        check("stl_keep", rs_data, 32'hA5A5A5A5);
        check("stl_wc", write_count, 32'd3);

        // Write presented in the cycle stall drops is accepted
        stall = 1'b0;
        wr(5'd9, 32'h00000099);
        tick();
        wr_off();
        rs_addr = 5'd9;
        #1;
        check("unstl_cv", {31'd0, commit_valid}, 32'h1);
        check("unstl_rd", rs_data, 32'h99);
        check("unstl_wc", write_count, 32'd4);

        // Back-to-back commits
        wr(5'd1, 32'h00000001);
        tick();
        check("b2b1_cv", {31'd0, commit_valid}, 32'h1);
        check("b2b1_ca", {27'd0, commit_addr}, 32'd1);
        wr(5'd2, 32'h00000002);
        tick();
        wr_off();
        rs_addr = 5'd1; rt_addr = 5'd2;
        #1;
        check("b2b2_cv", {31'd0, commit_valid}, 32'h1);
        check("b2b2_ca", {27'd0, commit_addr}, 32'd2);
        check("b2b2_cd", commit_data, 32'h2);
        check("b2b_rs", rs_data, 32'h1);
        check("b2b_rt", rt_data, 32'h2);
        check("b2b_wc", write_count, 32'd6);
        tick();
        check("b2b_end", {31'd0, commit_valid}, 32'h0);

        // HI/LO: no forwarding, stall blocks, reset wins
        hilo_write = 1'b1; hi_in = 32'h1; lo_in = 32'h2;
        #1;
        check("hilo_nofwd", hi_out, 32'h0);
        tick();
        check("hi_ld", hi_out, 32'h1);
        check("lo_ld", lo_out, 32'h2);
        stall = 1'b1; hi_in = 32'h5; lo_in = 32'h6;
        tick();
        check("hi_stl", hi_out, 32'h1);
        check("lo_stl", lo_out, 32'h2);
        stall = 1'b0; rst = 1'b1; hi_in = 32'h3; lo_in = 32'h4;
        tick();
        rst = 1'b0; hilo_write = 1'b0;
        #1;
        check("hi_rst", hi_out, 32'h0);
        check("lo_rst", lo_out, 32'h0);
        check("wc_rst", write_count, 32'h0);
        check("r1_rst", rs_data, 32'h0);

        // write_count wrap from all-ones
        force dut.write_count_q = 32'hFFFFFFFF;
        #1;
        release dut.write_count_q;
        #1;
        check("wc_pre", write_count, 32'hFFFFFFFF);
        wr(5'd4, 32'h00000044);
        tick();
        wr_off();
        check("wc_wrap", write_count, 32'h0);
        check("wrap_cv", {31'd0, commit_valid}, 32'h1);

        // Reset beats a simultaneous write, and kills the pending commit
        wr(5'd3, 32'h00000055);
        tick();
        check("r3_wc", write_count, 32'd1);
        wr(5'd3, 32'h00000066);
        rst = 1'b1;
        rs_addr = 5'd3;
        #1;
        check("rst_nofwd", rs_data, 32'h55);
        tick();
        rst = 1'b0;
        wr_off();
        #1;
        check("r3_after", rs_data, 32'h0);
        check("r3_cv", {31'd0, commit_valid}, 32'h0);
        check("r3_wc0", write_count, 32'h0);
        check("r3_ca", {27'd0, commit_addr}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter BYPASS_EN, default 1: 1 = same-cycle write-to-read forwarding; 0 = reads return stored value only.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port stall  input  1  pipeline stall; when high, no architectural write is accepted.
REQ-005 SHALL have port reg_write_to_file  input  1  GPR write enable from write-back stage.
REQ-006 SHALL have port reg_write_addr  input  5  GPR write index.
REQ-007 SHALL have port reg_write_data  input  32  GPR write data.
REQ-008 SHALL have port rs_addr  input  5  read port A index.
REQ-009 SHALL have port rt_addr  input  5  read port B index.
REQ-010 SHALL have port rs_data  output  32  read port A data, combinational.
REQ-011 SHALL have port rt_data  output  32  read port B data, combinational.
REQ-012 SHALL have port hilo_write  input  1  HI/LO write enable.
REQ-013 SHALL have port hi_in, lo_in  input  32 each  HI/LO write data.
REQ-014 SHALL have port hi_out, lo_out  output  32 each  registered HI/LO values.
REQ-015 SHALL have port commit_valid  output  1  one-cycle pulse per accepted GPR write.
REQ-016 SHALL have port commit_addr  output  5  index of the traced write.
REQ-017 SHALL have port commit_data  output  32  data of the traced write.
REQ-018 SHALL have port write_count  output  32  count of accepted GPR writes.

Function
REQ-019 SHALL hold 32 x 32-bit GPRs; register 0 reads 0 and is never written.
REQ-020 SHALL accept a GPR write at a rising edge iff reg_write_to_file=1, stall=0, rst=0, reg_write_addr!=0; the stored value is visible from the next cycle.
REQ-021 SHALL ignore enabled writes to address 0: no storage change, no trace, no count increment.
REQ-022 SHALL drive rs_data/rt_data combinationally from rs_addr/rt_addr, zero latency, independent of stall.
REQ-023 SHALL, when BYPASS_EN=1 and the REQ-020 acceptance condition is true in the current cycle with reg_write_addr equal to a nonzero read address, return reg_write_data on that port in the same cycle.
REQ-024 SHALL apply bypass to both ports independently; rs_addr=rt_addr=write address forwards on both.
REQ-025 SHALL NOT forward when stall=1 or rst=1, even if addresses match.
REQ-026 SHALL load hi_in/lo_in into HI/LO at the rising edge when hilo_write=1, stall=0, rst=0; HI/LO have no bypass.
REQ-027 SHALL register the trace: one cycle after an accepted write, commit_valid=1 with commit_addr/commit_data equal to the accepted address/data; otherwise commit_valid=0.
REQ-028 SHALL hold commit_addr/commit_data at their last values while commit_valid=0.
REQ-029 SHALL produce back-to-back commit_valid pulses for accepted writes on consecutive cycles, one per write, in order.
REQ-030 SHALL increment write_count by 1 per accepted write, modulo 2^32 (0xFFFFFFFF wraps to 0x00000000).
REQ-031 SHALL, on write + stall de-assertion in the same cycle, accept the write (stall sampled at that edge only).

Reset
REQ-032 SHALL, when rst=1 at a rising edge, clear all GPRs, HI, LO, commit_valid, commit_addr, commit_data and write_count to 0.
REQ-033 SHALL give rst priority over any simultaneous GPR or HI/LO write; that write is lost and not traced.
REQ-034 SHALL make commit_valid=0 the cycle after reset even if a write was accepted the cycle before reset.

Verification
REQ-035 SHALL test: write 0xDEADBEEF to r5, next cycle read rs_addr=5 -> rs_data=0xDEADBEEF; commit_valid=1, commit_addr=5, commit_data=0xDEADBEEF; write_count=1.
REQ-036 SHALL test: write 0x12345678 to r0 with enable -> rs_data for r0 stays 0, no commit_valid pulse, write_count unchanged.
REQ-037 SHALL test: BYPASS_EN=1, write 0xA5A5A5A5 to r7 while rs_addr=rt_addr=7 -> both outputs 0xA5A5A5A5 same cycle; repeat with stall=1 -> both show old r7 value, r7 unchanged afterwards.
REQ-038 SHALL test: hilo_write=1, hi_in=0x1, lo_in=0x2 -> next cycle hi_out=0x1, lo_out=0x2; same with rst=1 -> both 0.
REQ-039 SHALL test: preload write_count to 0xFFFFFFFF via 2^32-1 writes (or forced state), one more accepted write -> write_count=0x00000000.
REQ-040 SHALL test: write r3=0x55 then assert rst with simultaneous write r3=0x66 -> after reset r3=0, commit_valid=0, write_count=0.
